// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_adder.sv
// One-bit full-adder cell; the only arithmetic element of the serial adder.
module Adder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy,
    input  logic             clear
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_s_next;

    Adder u_adder (
        .A  (r_a_sh[0]),
        .B  (r_b_sh[0]),
        .Ci (r_carry),
        .S  (w_s),
        .Co (w_co)
    );

    // NOTE: shift-then-overwrite-MSB keeps this legal for WIDTH=1, where a
    // part-select s_sh[WIDTH-1:1] would be reversed; default assigned first so no latch.
    always_comb begin
        w_s_next            = r_s_sh >> 1;
        w_s_next[WIDTH-1]   = w_s;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, exactly like the flops it models.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_s_sh      <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clear) begin
            // Abort wins over every handshake; the last result stays visible.
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= ci;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_s_sh  <= w_s_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_sum       <= w_s_next;
                        r_co        <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign co        = r_co;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences a single instance of the team's 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first.
- Valid/ready handshakes on the operand side and the result side.
- Low-area alternative to the ripple-carry chain, for use where throughput of one add per WIDTH+2 cycles is acceptable.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 64.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion forces reset state immediately; release is synchronous to clk.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A, sampled at acceptance.
- b  input  WIDTH  operand B, sampled at acceptance.
- ci  input  1  carry-in, sampled at acceptance.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  result consumer ready.
- sum  output  WIDTH  registered result.
- co  output  1  registered carry-out.
- busy  output  1  high in RUN or DONE.
- clear  input  1  synchronous abort to IDLE; priority over all handshakes.

Behaviour:
- Reset values (rst_n low): state=IDLE, sum=0, co=0, out_valid=0, busy=0, counter=0, shift and carry registers=0.
- in_ready is decoded from state, so it reads 1 during reset.
- States: IDLE, RUN, DONE. The encoding is a localparam set.
- IDLE:
  - in_ready=1.
  - On in_valid: load a_sh<=a, b_sh<=b, carry<=ci, cnt<=0, go to RUN.
  - in_valid low: stay in IDLE.
- RUN, one bit per cycle:
  - Cell inputs are A=a_sh[0], B=b_sh[0], Ci=carry.
  - On each edge: a_sh and b_sh shift right by 1; s_sh<={S, s_sh[WIDTH-1:1]}; carry<=Co; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={S, s_sh[WIDTH-1:1]}, co<=Co, go to DONE.
  - in_valid is ignored in RUN; no operand capture occurs.
- DONE:
  - out_valid=1; sum and co are held stable.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - out_ready low: hold indefinitely.
  - sum and co keep their last value in IDLE and are only updated at RUN exit.
- Latency and throughput:
  - Acceptance edge is E0; out_valid is high in the cycle after edge E(WIDTH).
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH bit cycles, handshake in DONE).
  - A DONE-to-RUN bypass is not provided.
- clear (synchronous): from any state, next state=IDLE, cnt=0, out_valid=0. sum and co are not modified.
- WIDTH=1 boundary: RUN lasts exactly one cycle; cnt==0 is the terminal condition.
- Counter never exceeds WIDTH-1 in RUN. No wrap-around is observable outside RUN.
- Reset mid-RUN or mid-DONE: the operation is lost. No out_valid pulse is produced. After release the block is in IDLE with in_ready=1.
- Simultaneous clear and in_valid in IDLE: clear wins; no capture.
- Simultaneous clear and out_ready in DONE: go to IDLE.
- Arithmetic: {co, sum} == a + b + ci, computed modulo 2^(WIDTH+1).

Decomposition:
- Shared package serial_add_pkg:
  - state enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- Sub-module: the existing one-bit full-adder cell, module Adder, instantiated once as the only arithmetic element.
- FSM, counter and shift registers live in serial_add_ctrl.
- No other sub-modules.

Test Plan (WIDTH=8 unless noted):
- a=0x5A, b=0x3C, ci=0 accepted at E0 -> out_valid high after E8; sum=0x96, co=0. in_ready=0 from E0 until return to IDLE.
- a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 -> sum=0xFF, co=1. Then a=0x00, b=0x00, ci=0 -> sum=0x00, co=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/co stable, in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n pulsed low during RUN (cnt=3) -> outputs immediately at reset values, no out_valid. Next op a=0x10, b=0x20 -> sum=0x30, co=0.
- clear asserted in RUN (cnt=5) -> IDLE next cycle, out_valid never rises, prior sum retained. clear together with in_valid in IDLE -> no capture.
- WIDTH=1 build: a=1, b=1, ci=1 -> out_valid one cycle after acceptance edge, sum=1, co=1. Follow with 1000 random operand sets checked against a+b+ci.
